seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Serial bit-pattern transmitter for the sequence-detector path. It accepts a parallel pattern on a `start` pulse and shifts it out MSB-first, one bit per clock. It can repeat the pattern a programmable number of times with a programmable idle gap between repetitions. It is the stimulus/transmit end that feeds the serial `in` of the team's Mealy sequence detectors, and it is also used in-system to emit sync words.

## Interface
- `PAT_W`, default 6: pattern length in bits.
- `CNT_W`, default 4: width of the repeat count.
- `GAP_W`, default 4: width of the inter-repetition gap count.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `pattern`  in  PAT_W  pattern, captured on an accepted start. Bit PAT_W-1 is sent first.
- `repeat`  in  CNT_W  number of pattern transmissions, captured on an accepted start.
- `gap`  in  GAP_W  number of idle cycles between repetitions, captured on an accepted start.
- `abort`  in  1  synchronous cancel, honoured in any state.
- `out`  out  1  serial data bit (registered).
- `out_valid`  out  1  high while `out` carries a pattern bit.
- `busy`  out  1  high from the first bit through the last bit, including gaps.
- `done`  out  1  one-cycle pulse after the last bit of the last repetition.

## Operation
- States: IDLE, SEND, GAP, DONE.
- Reset values (asynchronous): state=IDLE; out=0, out_valid=0, busy=0, done=0; all internal registers 0.
- **IDLE**
  - If start=1 and repeat≠0: capture pattern, repeat and gap; load the shift register; go to SEND.
  - If start=1 and repeat=0: ignore the request; stay in IDLE; no done.
- **SEND**
  - out = shift register MSB; out_valid=1; busy=1.
  - Shift left by one each cycle; a bit counter runs 0..PAT_W-1.
  - On the last bit, decrement the remaining-repeat count.
    - If the count is now 0: go to DONE.
    - Else if gap=0: reload the pattern and stay in SEND. The next pattern follows back-to-back with no bubble.
    - Else: go to GAP.
- **GAP**
  - out=0, out_valid=0, busy=1.
  - Hold for exactly `gap` cycles, then reload the pattern and go to SEND.
- **DONE**
  - done=1, busy=0, out_valid=0, out=0, for one cycle; then go to IDLE.
- Start handling: start in SEND, GAP or DONE is ignored and not queued. Changes to pattern, repeat or gap after capture have no effect.
- Abort
  - In SEND, GAP or DONE: next cycle state=IDLE and all outputs 0; no done pulse.
  - In IDLE: no effect, and abort takes priority over a simultaneous start.
- Counter widths:
  - Bit counter: clog2(PAT_W) bits.
  - Repeat counter: CNT_W bits; repeat=2^CNT_W-1 is legal.
  - Gap counter: GAP_W bits; a gap value of 2^GAP_W-1 gives exactly that many idle cycles. No wrap-around is permitted.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Start accepted at edge t: the first bit appears in cycle t+1.
- Bit k of repetition r (both 0-based) appears in cycle t+1 + r·(PAT_W+gap) + k.
- busy is high for R·PAT_W + (R−1)·gap cycles, where R = repeat.
- done is high in the cycle after the last bit, with busy already low.
- The earliest next accepted start is the cycle after done, back in IDLE. Restart overhead is 2 cycles from the last bit to the next first bit.
- Reset asserted mid-transfer: outputs go to 0 immediately (asynchronously) and no done is generated.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum `gen_state_t` (2 bits: IDLE, SEND, GAP, DONE);
  - the constant `SYNC_PATTERN = 6'b101011`, which is also the detector target pattern.
- Sub-module `piso_shift`: PAT_W-bit parallel-in/serial-out register with load and shift enables and an MSB output.
- The top level holds the FSM and the repeat, gap and bit counters.

## Test plan
- Reset mid-SEND after 3 bits: outputs 0 within the reset cycle. After release, state is IDLE, there is no done, and a new start works normally.
- pattern=101011, repeat=1, gap=0: out=1,0,1,0,1,1 with out_valid=1 in cycles t+1..t+6; done=1 at t+7; busy low at t+7.
- pattern=101011, repeat=2, gap=0: 12 consecutive valid bits 101011101011, no out_valid bubble; done at t+13.
- pattern=110000, repeat=3, gap=2: busy for 22 cycles; out_valid low in cycles t+7,t+8 and t+15,t+16; done at t+23.
- start pulsed while busy, and start with repeat=0 in IDLE: both ignored; no extra bits; exactly one done per accepted start.
- abort in the 2nd gap cycle of the repeat=3/gap=2 case: next cycle state IDLE with busy, out_valid and out all 0, and no done.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and sequence detectors.
// Latency: n/a (package only).
// Backpressure: n/a.
package seq_pkg;

    // Generator FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    // Sync word, also the target pattern of the Mealy sequence detectors
    localparam logic [5:0] SYNC_PATTERN = 6'b101011;

endpackage

// File: rtl/seq_pattern_gen_piso_shift.sv
// Parallel-in/serial-out shift register; shifts left, zeros enter at the LSB.
// Latency: msb_o reflects a load or shift on the following cycle (registered).
// Backpressure: none; load has priority over shift.
// Ports: clk_i/reset_i clock and async active-high reset; load_i/din_i parallel load;
//        shift_i shift-left enable; msb_o current MSB. PAT_W must be at least 2.
module piso_shift #(
    parameter int PAT_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] din_i,
    output logic             msb_o
);

    logic [PAT_W-1:0] sh_q;
    logic [PAT_W-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = din_i;
        end else if (shift_i) begin
            sh_d = {sh_q[PAT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb_o = sh_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern transmitter with programmable repeat count and inter-repeat gap.
// Latency: first bit one cycle after an accepted start; all outputs registered.
// Backpressure: none; start is ignored (not queued) unless idle, abort cancels at any time.
// Ports: clk_i, reset_i (async active-high); start_i with pattern_i/repeat_i/gap_i captured on
//        acceptance; abort_i synchronous cancel; out_o serial bit, out_valid_o bit qualifier,
//        busy_o first bit through last bit incl. gaps, done_o one-cycle completion pulse.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 6,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [CNT_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             abort_i,
    output logic             out_o,
    output logic             out_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int               BIT_W    = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    gen_state_t       state_q,     state_d;
    logic [PAT_W-1:0] pat_q,       pat_d;
    logic [CNT_W-1:0] rep_q,       rep_d;
    logic [GAP_W-1:0] gap_q,       gap_d;
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic             sh_load;
    logic             sh_shift;
    logic [PAT_W-1:0] sh_din;

    // The shift register MSB is the serial output itself. Shifting past the last
    // bit leaves it all-zero, so out reads 0 in GAP/DONE without extra gating;
    // abort loads zeros for the same effect.
    piso_shift #(
        .PAT_W (PAT_W)
    ) u_piso (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .din_i   (sh_din),
        .msb_o   (out_o)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_din    = pat_q;

        case (state_q)
            IDLE: begin
                // abort outranks start here; repeat=0 requests are dropped
                if (!abort_i && start_i && (repeat_i != '0)) begin
                    state_d   = SEND;
                    pat_d     = pattern_i;
                    rep_d     = repeat_i;
                    gap_d     = gap_i;
                    bit_cnt_d = '0;
                    sh_load   = 1'b1;
                    sh_din    = pattern_i;
                end
            end
            SEND: begin
                if (abort_i) begin
                    state_d = IDLE;
                    sh_load = 1'b1;
                    sh_din  = '0;
                end else if (bit_cnt_q == LAST_BIT) begin
                    rep_d     = rep_q - CNT_W'(1);
                    bit_cnt_d = '0;
                    if (rep_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        sh_shift = 1'b1;
                    end else if (gap_q == '0) begin
                        // back-to-back repetition: reload directly, no bubble
                        sh_load = 1'b1;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                        sh_shift  = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    sh_shift  = 1'b1;
                end
            end
            GAP: begin
                // counts gap down to 1, so the full GAP_W range is usable without wrap
                if (abort_i) begin
                    state_d = IDLE;
                    sh_load = 1'b1;
                    sh_din  = '0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = SEND;
                    sh_load = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sh_load = 1'b1;
                sh_din  = '0;
            end
        endcase

        // status outputs are registered versions of the upcoming state
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d == SEND) || (state_d == GAP);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            rep_q       <= rep_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: hand-computed per-cycle vectors and cycle counts.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_pattern_gen;
    import seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] pattern;
    logic [3:0] rep;
    logic [3:0] gap;
    logic       abort;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    seq_pattern_gen #(
        .PAT_W (6),
        .CNT_W (4),
        .GAP_W (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .pattern_i   (pattern),
        .repeat_i    (rep),
        .gap_i       (gap),
        .abort_i     (abort),
        .out_o       (out),
        .out_valid_o (out_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [5:0] p, input logic [3:0] r, input logic [3:0] g);
        pattern = p;
        rep     = r;
        gap     = g;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Check cycles t+1..t+n; bit [n-j] of each vector is the expectation for t+j,
    // so the literals read left to right in time.
    task automatic run_check(input string tag, input int n,
                             input logic [31:0] e_out, input logic [31:0] e_vld,
                             input logic [31:0] e_busy, input logic [31:0] e_done);
        for (int j = 1; j <= n; j++) begin
            check($sformatf("%s_out_t%0d", tag, j),  {31'd0, out},       {31'd0, e_out[n-j]});
            check($sformatf("%s_vld_t%0d", tag, j),  {31'd0, out_valid}, {31'd0, e_vld[n-j]});
            check($sformatf("%s_busy_t%0d", tag, j), {31'd0, busy},      {31'd0, e_busy[n-j]});
            check($sformatf("%s_done_t%0d", tag, j), {31'd0, done},      {31'd0, e_done[n-j]});
            if (j < n) tick();
        end
    endtask

    // Count busy/valid cycles and locate done, bounded by a cycle budget.
    task automatic measure(output int busy_cnt, output int vld_cnt,
                           output int done_at, output int done_cnt);
        busy_cnt = 0;
        vld_cnt  = 0;
        done_at  = 0;
        done_cnt = 0;
        for (int j = 1; j <= 400; j++) begin
            if (busy)      busy_cnt++;
            if (out_valid) vld_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = j;
            end
            if (done_at != 0 && j >= done_at + 3) break;
            tick();
        end
    endtask

    task automatic quiet(input string tag, input int n);
        for (int j = 1; j <= n; j++) begin
            check($sformatf("%s_busy_%0d", tag, j), {31'd0, busy},      32'd0);
            check($sformatf("%s_vld_%0d", tag, j),  {31'd0, out_valid}, 32'd0);
            check($sformatf("%s_done_%0d", tag, j), {31'd0, done},      32'd0);
            check($sformatf("%s_out_%0d", tag, j),  {31'd0, out},       32'd0);
            tick();
        end
    endtask

    int bc, vc, da, dc;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        rep     = '0;
        gap     = '0;
        abort   = 1'b0;
        #12;
        quiet("reset", 1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // single transmission of the sync word
        accept(SYNC_PATTERN, 4'd1, 4'd0);
        run_check("r1g0", 8, 32'b10101100, 32'b11111100, 32'b11111100, 32'b00000010);
        tick();

        // two repetitions back-to-back, no valid bubble
        accept(6'b101011, 4'd2, 4'd0);
        run_check("r2g0", 14, 32'b10101110101100, 32'b11111111111100,
                  32'b11111111111100, 32'b00000000000010);
        tick();

        // three repetitions with a two-cycle gap
        accept(6'b110000, 4'd3, 4'd2);
        run_check("r3g2", 24, 32'b110000001100000011000000, 32'b111111001111110011111100,
                  32'b111111111111111111111100, 32'b000000000000000000000010);
        tick();

        // start held high while busy with changed inputs: ignored, capture unaffected
        accept(6'b101011, 4'd1, 4'd0);
        start   = 1'b1;
        pattern = 6'b010101;
        rep     = 4'd15;
        gap     = 4'd3;
        run_check("busy_start", 8, 32'b10101100, 32'b11111100, 32'b11111100, 32'b00000010);
        start = 1'b0;
        tick();
        quiet("after_busy_start", 3);

        // repeat=0 request is dropped
        accept(6'b111111, 4'd0, 4'd1);
        quiet("rep0", 6);

        // abort outranks a simultaneous start in IDLE
        abort = 1'b1;
        accept(6'b111111, 4'd1, 4'd0);
        abort = 1'b0;
        quiet("idle_abort", 4);

        // abort in the second gap cycle of the repeat=3/gap=2 case
        accept(6'b110000, 4'd3, 4'd2);
        run_check("pre_abort", 8, 32'b11000000, 32'b11111100, 32'b11111111, 32'b00000000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        quiet("post_abort", 20);

        // max gap: 2 reps, gap 15 -> busy 27, valid 12, done at t+28
        accept(6'b100001, 4'd2, 4'd15);
        measure(bc, vc, da, dc);
        check("gap15_busy", bc, 32'd27);
        check("gap15_vld",  vc, 32'd12);
        check("gap15_done_at", da, 32'd28);
        check("gap15_done_cnt", dc, 32'd1);
        tick();

        // max repeat: 15 reps, no gap -> busy 90, valid 90, done at t+91
        accept(6'b111111, 4'd15, 4'd0);
        measure(bc, vc, da, dc);
        check("rep15_busy", bc, 32'd90);
        check("rep15_vld",  vc, 32'd90);
        check("rep15_done_at", da, 32'd91);
        check("rep15_done_cnt", dc, 32'd1);
        tick();

        // asynchronous reset mid-SEND after three bits
        accept(6'b111111, 4'd2, 4'd0);
        run_check("pre_reset", 3, 32'b111, 32'b111, 32'b111, 32'b000);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_out",  {31'd0, out},       32'd0);
        check("rst_async_vld",  {31'd0, out_valid}, 32'd0);
        check("rst_async_busy", {31'd0, busy},      32'd0);
        check("rst_async_done", {31'd0, done},      32'd0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        quiet("post_reset", 5);
        accept(6'b101011, 4'd1, 4'd0);
        run_check("after_reset", 8, 32'b10101100, 32'b11111100, 32'b11111100, 32'b00000010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
